// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive controller: FSM states,
// PID codes, rx_packet encoding and the SYNC byte.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_SYNC,
        WAIT_PID,
        RCV_TOKEN,
        RCV_DATA,
        STORE,
        EOP_WAIT,
        DONE,
        ERR,
        ERR_WAIT
    } state_t;

    typedef enum logic [1:0] {
        PID_TOKEN,
        PID_DATA,
        PID_HANDSHAKE,
        PID_NONE
    } pid_class_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [2:0] RX_NONE  = 3'd0;
    localparam logic [2:0] RX_OUT   = 3'd1;
    localparam logic [2:0] RX_IN    = 3'd2;
    localparam logic [2:0] RX_DATA0 = 3'd3;
    localparam logic [2:0] RX_DATA1 = 3'd4;
    localparam logic [2:0] RX_ACK   = 3'd5;
    localparam logic [2:0] RX_NAK   = 3'd6;
    localparam logic [2:0] RX_STALL = 3'd7;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Byte counter increment that sticks at the top value instead of wrapping.
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/usb_pid_decode.sv
// Combinational PID check: validates the complement nibble and maps the
// PID to its packet class and rx_packet code.
module usb_pid_decode
    import usb_rx_pkg::*;
(
    input  logic [7:0] rcv_data,
    output logic       valid,
    output pid_class_t pid_class,
    output logic [2:0] rx_packet
);

    always_comb begin
        pid_class = PID_NONE;
        rx_packet = RX_NONE;
        case (rcv_data[3:0])
            PID_OUT:   begin pid_class = PID_TOKEN;     rx_packet = RX_OUT;   end
            PID_IN:    begin pid_class = PID_TOKEN;     rx_packet = RX_IN;    end
            PID_DATA0: begin pid_class = PID_DATA;      rx_packet = RX_DATA0; end
            PID_DATA1: begin pid_class = PID_DATA;      rx_packet = RX_DATA1; end
            PID_ACK:   begin pid_class = PID_HANDSHAKE; rx_packet = RX_ACK;   end
            PID_NAK:   begin pid_class = PID_HANDSHAKE; rx_packet = RX_NAK;   end
            PID_STALL: begin pid_class = PID_HANDSHAKE; rx_packet = RX_STALL; end
            default:   ;
        endcase
        valid = (rcv_data[7:4] == ~rcv_data[3:0]) && (pid_class != PID_NONE);
    end

endmodule

// File: rtl/usb_rx_controller.sv
// USB receive packet controller: tracks SYNC/PID/payload/EOP sequencing,
// strobes payload bytes into the RX FIFO and flags protocol errors.
module usb_rx_controller
    import usb_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic [6:0] buffer_occupancy,
    output logic       rcving,
    output logic       w_enable,
    output logic       flush,
    output logic       r_error,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready
);

    state_t     state_reg, state_next;
    logic [6:0] count_reg, count_next;
    logic [6:0] count_eff;
    logic       eop_pend_reg, eop_pend_next;
    logic       eop_seen_reg, eop_seen_next;
    logic       r_error_reg, r_error_next;
    logic [2:0] rx_packet_reg, rx_packet_next;
    logic       flush_reg, flush_next;
    logic       ready_reg, ready_next;
    logic       eop_now;

    logic       pid_valid;
    pid_class_t pid_class;
    logic [2:0] pid_packet;

    // Framing is driven purely by byte_received/eop; the bit strobe is not needed here.
    logic       unused_ok;
    assign unused_ok = shift_enable;

    usb_pid_decode u_pid_decode (
        .rcv_data  (rcv_data),
        .valid     (pid_valid),
        .pid_class (pid_class),
        .rx_packet (pid_packet)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            eop_pend_reg  <= 1'b0;
            eop_seen_reg  <= 1'b0;
            r_error_reg   <= 1'b0;
            rx_packet_reg <= RX_NONE;
            flush_reg     <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            eop_pend_reg  <= eop_pend_next;
            eop_seen_reg  <= eop_seen_next;
            r_error_reg   <= r_error_next;
            rx_packet_reg <= rx_packet_next;
            flush_reg     <= flush_next;
            ready_reg     <= ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        eop_pend_next  = eop_pend_reg;
        eop_seen_next  = eop_seen_reg;
        r_error_next   = r_error_reg;
        rx_packet_next = rx_packet_reg;
        flush_next     = 1'b0;
        ready_next     = 1'b0;
        count_eff      = byte_received ? sat_inc(count_reg) : count_reg;

        case (state_reg)
            IDLE: begin
                if (d_edge) begin
                    state_next    = WAIT_SYNC;
                    r_error_next  = 1'b0;
                    count_next    = '0;
                    eop_pend_next = 1'b0;
                    eop_seen_next = 1'b0;
                end
            end
            WAIT_SYNC: begin
                if (byte_received && rcv_data == SYNC_BYTE && !eop)
                    state_next = WAIT_PID;
                else if (byte_received || eop)
                    state_next = ERR;
            end
            WAIT_PID: begin
                if (byte_received) begin
                    if (!pid_valid) begin
                        state_next = ERR;
                    end else begin
                        rx_packet_next = pid_packet;
                        count_next     = '0;
                        case (pid_class)
                            PID_TOKEN:     state_next = RCV_TOKEN;
                            PID_DATA:      state_next = RCV_DATA;
                            default:       state_next = EOP_WAIT;
                        endcase
                        // A same-cycle eop only completes a handshake.
                        if (eop)
                            state_next = (pid_class == PID_HANDSHAKE) ? DONE : ERR;
                        flush_next = (pid_class == PID_DATA) && !eop;
                    end
                end else if (eop) begin
                    state_next = ERR;
                end
            end
            RCV_TOKEN: begin
                count_next = count_eff;
                if (byte_received && count_eff > 7'd2)
                    state_next = ERR;
                else if (eop)
                    state_next = (count_eff == 7'd2) ? DONE : ERR;
            end
            RCV_DATA: begin
                if (byte_received) begin
                    if (buffer_occupancy >= 7'(MAX_PAYLOAD)) begin
                        state_next = ERR;
                    end else begin
                        state_next    = STORE;
                        eop_pend_next = eop;
                    end
                end else if (eop) begin
                    if (count_reg >= 7'd2) begin
                        state_next = DONE;
                        ready_next = 1'b1;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            STORE: begin
                count_next    = sat_inc(count_reg);
                eop_pend_next = 1'b0;
                // An eop that came with this byte is judged after the byte counts.
                if (eop_pend_reg || eop) begin
                    if (count_next >= 7'd2) begin
                        state_next = DONE;
                        ready_next = 1'b1;
                    end else begin
                        state_next = ERR;
                    end
                end else begin
                    state_next = RCV_DATA;
                end
            end
            EOP_WAIT: begin
                if (byte_received)
                    state_next = ERR;
                else if (eop)
                    state_next = DONE;
            end
            DONE: begin
                if (d_edge)
                    state_next = IDLE;
            end
            ERR: begin
                state_next = ERR_WAIT;
            end
            ERR_WAIT: begin
                if (eop_seen_reg && d_edge)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        eop_now = eop || (state_reg == STORE && eop_pend_reg);
        if (state_next == ERR) begin
            r_error_next   = 1'b1;
            rx_packet_next = RX_NONE;
        end
        if (eop_now && (state_next == ERR || state_reg == ERR || state_reg == ERR_WAIT))
            eop_seen_next = 1'b1;
    end

    assign rcving        = (state_reg != IDLE) && (state_reg != DONE);
    assign w_enable      = (state_reg == STORE);
    assign flush         = flush_reg;
    assign r_error       = r_error_reg;
    assign rx_packet     = rx_packet_reg;
    assign rx_data_ready = ready_reg;

endmodule

// File: tb/tb_usb_rx_controller.sv
// Directed-vector bench for usb_rx_controller with a scoreboard queue of
// expected flush / FIFO-write / data-ready events checked by a monitor.
module tb_usb_rx_controller;

    localparam int K_FLUSH = 0;
    localparam int K_WR    = 1;
    localparam int K_RDY   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       rcving, w_enable, flush, r_error, rx_data_ready;
    logic [2:0] rx_packet;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    usb_rx_controller #(.MAX_PAYLOAD(64)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .d_edge           (d_edge),
        .eop              (eop),
        .shift_enable     (shift_enable),
        .byte_received    (byte_received),
        .rcv_data         (rcv_data),
        .buffer_occupancy (buffer_occupancy),
        .rcving           (rcving),
        .w_enable         (w_enable),
        .flush            (flush),
        .r_error          (r_error),
        .rx_packet        (rx_packet),
        .rx_data_ready    (rx_data_ready)
    );

    always #5 clk = ~clk;

    task automatic push(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [7:0] data, input string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event data=%02h, required none", name, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("FAIL %s: got kind=%0d data=%02h, required kind=%0d data=%02h",
                         name, kind, data, e.kind, e.data);
            end else begin
                $display("txn %s data=%02h", name, data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (flush)         pop_check(K_FLUSH, 8'h00, "flush");
        if (w_enable)      pop_check(K_WR, rcv_data, "w_enable");
        if (rx_data_ready) pop_check(K_RDY, {5'b0, rx_packet}, "rx_data_ready");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end else begin
            $display("chk %s = %02h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_eop);
        rcv_data      = b;
        byte_received = 1'b1;
        eop           = with_eop;
        tick();
        byte_received = 1'b0;
        eop           = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        tick();
    endtask

    task automatic status(input string tag, input logic rcv_req, input logic err_req,
                          input logic [2:0] pkt_req);
        @(negedge clk);
        chk({tag, "_rcving"}, {7'b0, rcving}, {7'b0, rcv_req});
        chk({tag, "_r_error"}, {7'b0, r_error}, {7'b0, err_req});
        chk({tag, "_rx_packet"}, {5'b0, rx_packet}, {5'b0, pkt_req});
        tick();
    endtask

    initial begin
        logic [7:0] hs_pid [2];
        logic [2:0] hs_pkt [2];
        hs_pid[0] = 8'h5A; hs_pkt[0] = 3'd6;
        hs_pid[1] = 8'h1E; hs_pkt[1] = 3'd7;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", {rcving, w_enable, flush, r_error, rx_packet, rx_data_ready}, 8'h00);
        tick();
        n_rst = 1'b1;
        tick();

        // OUT token, two bytes, eop
        pulse_edge();
        status("out_start", 1'b1, 1'b0, 3'd0);
        send_byte(8'h80, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_eop();
        status("out_done", 1'b0, 1'b0, 3'd1);
        pulse_edge();

        // DATA0 with five payload bytes
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push(K_WR, 8'hA0 + 8'(i));
            send_byte(8'hA0 + 8'(i), 1'b0);
        end
        push(K_RDY, 8'h03);
        send_eop();
        status("data0_done", 1'b0, 1'b0, 3'd3);
        pulse_edge();

        // Bad PID: rcving held through an early edge until eop then edge
        pulse_edge();
        send_byte(8'h80, 1'b0);
        send_byte(8'h3C, 1'b0);
        status("badpid_err", 1'b1, 1'b1, 3'd0);
        pulse_edge();
        status("badpid_edge_no_eop", 1'b1, 1'b1, 3'd0);
        send_eop();
        status("badpid_eop", 1'b1, 1'b1, 3'd0);
        pulse_edge();
        status("badpid_idle", 1'b0, 1'b1, 3'd0);

        // DATA1 into a full FIFO
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'h4B, 1'b0);
        buffer_occupancy = 7'd64;
        send_byte(8'h77, 1'b0);
        status("full_err", 1'b1, 1'b1, 3'd0);
        buffer_occupancy = 7'd0;
        send_eop();
        pulse_edge();

        // ACK with a stray byte, then a clean ACK clears r_error at its first edge
        pulse_edge();
        send_byte(8'h80, 1'b0);
        send_byte(8'hD2, 1'b0);
        status("ack_pid", 1'b1, 1'b0, 3'd5);
        send_byte(8'h00, 1'b0);
        status("ack_extra_err", 1'b1, 1'b1, 3'd0);
        send_eop();
        pulse_edge();
        status("ack_err_sticky", 1'b0, 1'b1, 3'd0);
        pulse_edge();
        status("ack2_start", 1'b1, 1'b0, 3'd0);
        send_byte(8'h80, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_eop();
        status("ack2_done", 1'b0, 1'b0, 3'd5);
        pulse_edge();

        // NAK and STALL handshakes
        for (int i = 0; i < 2; i++) begin
            pulse_edge();
            send_byte(8'h80, 1'b0);
            send_byte(hs_pid[i], 1'b0);
            send_eop();
            status("handshake", 1'b0, 1'b0, hs_pkt[i]);
            pulse_edge();
        end

        // IN token cut short after one byte
        pulse_edge();
        send_byte(8'h80, 1'b0);
        send_byte(8'h69, 1'b0);
        send_byte(8'h01, 1'b0);
        send_eop();
        status("in_short", 1'b1, 1'b1, 3'd0);
        pulse_edge();

        // DATA0 with only one byte before eop
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'hC3, 1'b0);
        push(K_WR, 8'h11);
        send_byte(8'h11, 1'b0);
        send_eop();
        status("data_short", 1'b1, 1'b1, 3'd0);
        pulse_edge();
        status("data_short_idle", 1'b0, 1'b1, 3'd0);

        // DATA1 whose last byte arrives together with eop
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'h4B, 1'b0);
        push(K_WR, 8'hAA);
        send_byte(8'hAA, 1'b0);
        push(K_WR, 8'h55);
        push(K_RDY, 8'h04);
        send_byte(8'h55, 1'b1);
        status("data1_same_eop", 1'b0, 1'b0, 3'd4);
        pulse_edge();

        // Reset during the third data byte, then a clean DATA0
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'hC3, 1'b0);
        push(K_WR, 8'h01);
        send_byte(8'h01, 1'b0);
        push(K_WR, 8'h02);
        send_byte(8'h02, 1'b0);
        rcv_data      = 8'h03;
        byte_received = 1'b1;
        n_rst         = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {rcving, w_enable, flush, r_error, rx_packet, rx_data_ready}, 8'h00);
        tick();
        byte_received = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_FLUSH, 8'h00);
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push(K_WR, 8'h40 + 8'(i));
            send_byte(8'h40 + 8'(i), 1'b0);
        end
        push(K_RDY, 8'h03);
        send_eop();
        status("post_reset_done", 1'b0, 1'b0, 3'd3);
        pulse_edge();

        repeat (4) tick();
        @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
